// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for an N-stage MIPS pipeline, plus an interrupt sequencing FSM.
// Optional single-step debug hold is compiled in with `HAZARD_DEBUG_EN.
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int REG_AW     = 5,
    parameter int LOAD_RDY   = 4,
    parameter int CNT_W      = 16,
    localparam int NP        = NUM_STAGES - 2,
    localparam int FW        = $clog2(NUM_STAGES - 1)
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef HAZARD_DEBUG_EN
    input  logic                   debug_en,
    input  logic                   debug_step,
`endif
    input  logic [REG_AW-1:0]      id_rs,
    input  logic [REG_AW-1:0]      id_rt,
    input  logic                   id_rs_used,
    input  logic                   id_rt_used,
    input  logic                   id_is_store,
    input  logic                   id_branch_tk,
    input  logic                   id_eret,
    input  logic [NP-1:0]          st_wen,
    input  logic [NP*REG_AW-1:0]   st_waddr,
    input  logic [NP-1:0]          st_is_load,
    input  logic                   mem_busy,
    input  logic                   irq_req,
    input  logic                   irq_mask,
    output logic [FW-1:0]          fwd_a,
    output logic [FW-1:0]          fwd_b,
    output logic                   st_fwd_mem,
    output logic [NUM_STAGES-1:0]  stage_en,
    output logic [NUM_STAGES-1:0]  stage_rst,
    output logic                   irq_take,
    output logic                   in_service,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt,
    output logic [1:0]             fsm_state
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_TAKE    = 2'd2;
    localparam logic [1:0] S_SERVICE = 2'd3;

    // Handshake-free block: every control is a same-cycle function of the inputs;
    // the pipeline consumes stage_en/stage_rst on the next clock edge.

    logic [1:0]    state, state_nx;
    logic          hold;
    logic [FW-1:0] fwd_a_c, fwd_b_c;
    logic          stall_a, stall_b, mem_c;
    logic          load_stall;
    logic          eret_acc;
    logic          stall_any, flush_any;

`ifdef HAZARD_DEBUG_EN
    logic step_q, adv_q;

    // adv_q is high for exactly the cycle after a debug_step rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= 1'b0;
            adv_q  <= 1'b0;
        end else begin
            step_q <= debug_step;
            adv_q  <= debug_step & ~step_q;
        end
    end

    assign hold = ~rst & debug_en & ~adv_q;
`else
    assign hold = 1'b0;
`endif

    // Scan from the oldest producer down so the youngest (lowest index) match wins.
    // A load counts as forwardable once its stage feeds the register at index LOAD_RDY.
    always_comb begin
        fwd_a_c = '0;
        fwd_b_c = '0;
        stall_a = 1'b0;
        stall_b = 1'b0;
        mem_c   = 1'b0;
        for (int k = NP - 1; k >= 0; k--) begin
            if (id_rs_used && st_wen[k] && st_waddr[k*REG_AW +: REG_AW] != '0 &&
                st_waddr[k*REG_AW +: REG_AW] == id_rs) begin
                if (st_is_load[k] && (k + 3) < LOAD_RDY) begin
                    stall_a = 1'b1;
                    fwd_a_c = '0;
                end else begin
                    stall_a = 1'b0;
                    fwd_a_c = FW'(k + 1);
                end
            end
            if (id_rt_used && st_wen[k] && st_waddr[k*REG_AW +: REG_AW] != '0 &&
                st_waddr[k*REG_AW +: REG_AW] == id_rt) begin
                fwd_b_c = '0;
                stall_b = 1'b0;
                mem_c   = 1'b0;
                if (st_is_load[k] && (k + 3) < LOAD_RDY) begin
                    // Store data is not needed until MEM, so it can pick up the load result there.
                    if (k == 0 && id_is_store) mem_c = 1'b1;
                    else                       stall_b = 1'b1;
                end else begin
                    fwd_b_c = FW'(k + 1);
                end
            end
        end
    end

    assign load_stall = ~rst & (stall_a | stall_b);
    assign fwd_a      = rst ? '0 : fwd_a_c;
    assign fwd_b      = rst ? '0 : fwd_b_c;
    assign st_fwd_mem = ~rst & mem_c;

    assign irq_take   = ~rst & ~hold & (state == S_TAKE);
    assign in_service = ~rst & (state == S_SERVICE);
    assign eret_acc   = ~rst & ~hold & ~mem_busy & ~load_stall & id_eret & (state == S_SERVICE);
    assign fsm_state  = state;

    always_comb begin
        stage_en  = '1;
        stage_rst = '0;
        if (rst) begin
            stage_rst = '1;
        end else if (hold || mem_busy) begin
            stage_en = '0;
        end else if (load_stall) begin
            stage_en[0]  = 1'b0;
            stage_en[1]  = 1'b0;
            stage_rst[2] = 1'b1;
        end else if (irq_take) begin
            stage_rst[1] = 1'b1;
            stage_rst[2] = 1'b1;
        end else if (id_branch_tk || eret_acc) begin
            stage_rst[1] = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (irq_req && !irq_mask) state_nx = S_WAIT;
            S_WAIT: begin
                if (!irq_req)                                       state_nx = S_IDLE;
                else if (!mem_busy && !load_stall && !id_branch_tk) state_nx = S_TAKE;
            end
            S_TAKE:    state_nx = S_SERVICE;
            S_SERVICE: if (eret_acc) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)        state <= S_IDLE;
        else if (!hold) state <= state_nx;
    end

    assign stall_any = ~rst & ~hold & (mem_busy | load_stall);
    assign flush_any = ~rst & (|stage_rst);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_any && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_any && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (default parameters: 5 stages, 5-bit regs, 16-bit counters).
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs, id_rt;
    logic        id_rs_used, id_rt_used, id_is_store, id_branch_tk, id_eret;
    logic [2:0]  st_wen, st_is_load;
    logic [14:0] st_waddr;
    logic        mem_busy, irq_req, irq_mask;
    logic [1:0]  fwd_a, fwd_b, fsm_state;
    logic        st_fwd_mem, irq_take, in_service;
    logic [4:0]  stage_en, stage_rst;
    logic [15:0] stall_cnt, flush_cnt;
`ifdef HAZARD_DEBUG_EN
    logic        debug_en = 1'b0;
    logic        debug_step = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
`ifdef HAZARD_DEBUG_EN
        .debug_en(debug_en), .debug_step(debug_step),
`endif
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_is_store(id_is_store), .id_branch_tk(id_branch_tk), .id_eret(id_eret),
        .st_wen(st_wen), .st_waddr(st_waddr), .st_is_load(st_is_load),
        .mem_busy(mem_busy), .irq_req(irq_req), .irq_mask(irq_mask),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .st_fwd_mem(st_fwd_mem),
        .stage_en(stage_en), .stage_rst(stage_rst), .irq_take(irq_take),
        .in_service(in_service), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .fsm_state(fsm_state)
    );

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_rs_used = 1'b0; id_rt_used = 1'b0;
        id_is_store = 1'b0; id_branch_tk = 1'b0; id_eret = 1'b0;
        st_wen = 3'b000; st_waddr = 15'd0; st_is_load = 3'b000;
        mem_busy = 1'b0; irq_req = 1'b0; irq_mask = 1'b0;
    endtask

    // Inputs change on the falling edge; checks happen 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1; st_wen = 3'b001; st_waddr = {5'd0, 5'd0, 5'd8}; id_rs = 5'd8; id_rs_used = 1'b1;
        irq_req = 1'b1; mem_busy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (stage_rst !== 5'h1F) begin n_err++; $display("FAIL reset_stage_rst got %h exp 1f", stage_rst); end
        n_vec++; if (stage_en !== 5'h1F) begin n_err++; $display("FAIL reset_stage_en got %h exp 1f", stage_en); end
        n_vec++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0 || st_fwd_mem !== 1'b0) begin n_err++; $display("FAIL reset_fwd got a=%0d b=%0d m=%0b exp 0 0 0", fwd_a, fwd_b, st_fwd_mem); end
        n_vec++; if (irq_take !== 1'b0 || in_service !== 1'b0 || fsm_state !== 2'd0) begin n_err++; $display("FAIL reset_fsm got take=%0b svc=%0b st=%0d exp 0 0 0", irq_take, in_service, fsm_state); end
        n_vec++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt got %0d %0d exp 0 0", stall_cnt, flush_cnt); end
        @(negedge clk);
        rst = 1'b0; clear_inputs();
        #1;
        n_vec++; if (stage_en !== 5'h1F || stage_rst !== 5'h00) begin n_err++; $display("FAIL post_reset_ctrl got en=%h rst=%h exp 1f 00", stage_en, stage_rst); end
    endtask

    task automatic test_forward();
        next_cycle();
        st_wen = 3'b001; st_waddr = {5'd0, 5'd0, 5'd8}; id_rs = 5'd8; id_rs_used = 1'b1; #1;
        n_vec++; if (fwd_a !== 2'd1) begin n_err++; $display("FAIL fwd_stage2 got %0d exp 1", fwd_a); end
        st_wen = 3'b011; st_waddr = {5'd0, 5'd8, 5'd8}; #1;
        n_vec++; if (fwd_a !== 2'd1) begin n_err++; $display("FAIL fwd_nearest got %0d exp 1", fwd_a); end
        st_wen = 3'b011; st_waddr = {5'd0, 5'd0, 5'd0}; id_rs = 5'd0; #1;
        n_vec++; if (fwd_a !== 2'd0) begin n_err++; $display("FAIL fwd_r0 got %0d exp 0", fwd_a); end
        st_wen = 3'b110; st_waddr = {5'd7, 5'd8, 5'd8}; id_rs = 5'd8; id_rt = 5'd7; id_rt_used = 1'b1; #1;
        n_vec++; if (fwd_a !== 2'd2 || fwd_b !== 2'd3) begin n_err++; $display("FAIL fwd_stage3_4 got a=%0d b=%0d exp 2 3", fwd_a, fwd_b); end
        id_rs_used = 1'b0; st_wen = 3'b000; #1;
        n_vec++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0 || stage_en !== 5'h1F) begin n_err++; $display("FAIL fwd_unused got a=%0d b=%0d en=%h exp 0 0 1f", fwd_a, fwd_b, stage_en); end
    endtask

    task automatic test_load_use();
        next_cycle();
        st_wen = 3'b001; st_is_load = 3'b001; st_waddr = {5'd0, 5'd0, 5'd9};
        id_rt = 5'd9; id_rt_used = 1'b1; id_rs = 5'd2; id_rs_used = 1'b1; #1;
        n_vec++; if (stage_en !== 5'b11100 || stage_rst !== 5'b00100) begin n_err++; $display("FAIL load_use_stall got en=%b rst=%b exp 11100 00100", stage_en, stage_rst); end
        n_vec++; if (fwd_b !== 2'd0) begin n_err++; $display("FAIL load_use_fwd0 got %0d exp 0", fwd_b); end
        next_cycle();
        st_wen = 3'b010; st_is_load = 3'b010; st_waddr = {5'd0, 5'd9, 5'd0};
        id_rt = 5'd9; id_rt_used = 1'b1; #1;
        n_vec++; if (fwd_b !== 2'd2 || stage_en !== 5'h1F || stage_rst !== 5'h00) begin n_err++; $display("FAIL load_use_next got b=%0d en=%h rst=%h exp 2 1f 00", fwd_b, stage_en, stage_rst); end
    endtask

    task automatic test_store_fwd();
        next_cycle();
        st_wen = 3'b001; st_is_load = 3'b001; st_waddr = {5'd0, 5'd0, 5'd9};
        id_is_store = 1'b1; id_rt = 5'd9; id_rt_used = 1'b1; id_rs = 5'd3; id_rs_used = 1'b1; #1;
        n_vec++; if (st_fwd_mem !== 1'b1 || stage_en !== 5'h1F || stage_rst !== 5'h00) begin n_err++; $display("FAIL store_fwd got m=%0b en=%h rst=%h exp 1 1f 00", st_fwd_mem, stage_en, stage_rst); end
        id_rs = 5'd9; id_rt = 5'd4; #1;
        n_vec++; if (stage_en !== 5'b11100 || st_fwd_mem !== 1'b0) begin n_err++; $display("FAIL store_base_stall got en=%b m=%0b exp 11100 0", stage_en, st_fwd_mem); end
    endtask

    task automatic test_irq();
        pulse_reset();
        st_wen = 3'b001; st_is_load = 3'b001; st_waddr = {5'd0, 5'd0, 5'd9};
        id_rs = 5'd9; id_rs_used = 1'b1; irq_req = 1'b1; #1;
        n_vec++; if (stage_en !== 5'b11100 || irq_take !== 1'b0) begin n_err++; $display("FAIL irq_stall got en=%b take=%0b exp 11100 0", stage_en, irq_take); end
        next_cycle(); irq_req = 1'b1; #1;
        n_vec++; if (fsm_state !== 2'd1 || irq_take !== 1'b0 || stage_rst !== 5'h00) begin n_err++; $display("FAIL irq_wait got st=%0d take=%0b rst=%h exp 1 0 00", fsm_state, irq_take, stage_rst); end
        next_cycle(); irq_req = 1'b1; #1;
        n_vec++; if (irq_take !== 1'b1 || stage_rst !== 5'b00110) begin n_err++; $display("FAIL irq_take got take=%0b rst=%b exp 1 00110", irq_take, stage_rst); end
        next_cycle(); irq_req = 1'b1; #1;
        n_vec++; if (in_service !== 1'b1 || irq_take !== 1'b0 || stage_rst !== 5'h00) begin n_err++; $display("FAIL irq_service got svc=%0b take=%0b rst=%h exp 1 0 00", in_service, irq_take, stage_rst); end
        next_cycle(); irq_req = 1'b1; #1;
        n_vec++; if (in_service !== 1'b1 || fsm_state !== 2'd3) begin n_err++; $display("FAIL irq_no_nest got svc=%0b st=%0d exp 1 3", in_service, fsm_state); end
        next_cycle(); id_eret = 1'b1; #1;
        n_vec++; if (stage_rst !== 5'b00010) begin n_err++; $display("FAIL eret_flush got %b exp 00010", stage_rst); end
        next_cycle(); id_eret = 1'b1; #1;
        n_vec++; if (in_service !== 1'b0 || fsm_state !== 2'd0 || stage_rst !== 5'h00) begin n_err++; $display("FAIL eret_nop got svc=%0b st=%0d rst=%h exp 0 0 00", in_service, fsm_state, stage_rst); end
        next_cycle(); irq_req = 1'b1; irq_mask = 1'b1;
        next_cycle(); #1;
        n_vec++; if (fsm_state !== 2'd0) begin n_err++; $display("FAIL irq_masked got st=%0d exp 0", fsm_state); end
        irq_req = 1'b1;
        next_cycle(); irq_req = 1'b1; id_branch_tk = 1'b1; #1;
        n_vec++; if (fsm_state !== 2'd1 || stage_rst !== 5'b00010) begin n_err++; $display("FAIL wait_branch got st=%0d rst=%b exp 1 00010", fsm_state, stage_rst); end
        next_cycle(); #1;
        n_vec++; if (fsm_state !== 2'd1) begin n_err++; $display("FAIL wait_blocked got st=%0d exp 1", fsm_state); end
        next_cycle(); #1;
        n_vec++; if (fsm_state !== 2'd0 || irq_take !== 1'b0) begin n_err++; $display("FAIL wait_drop got st=%0d take=%0b exp 0 0", fsm_state, irq_take); end
    endtask

    task automatic test_mem_busy();
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            mem_busy = 1'b1; id_branch_tk = 1'b1; #1;
            n_vec++; if (stage_en !== 5'h00 || stage_rst !== 5'h00) begin n_err++; $display("FAIL mem_busy_%0d got en=%h rst=%h exp 00 00", i, stage_en, stage_rst); end
            next_cycle();
        end
        id_branch_tk = 1'b1; #1;
        n_vec++; if (stall_cnt !== 16'd3 || flush_cnt !== 16'd0) begin n_err++; $display("FAIL mem_busy_cnt got %0d %0d exp 3 0", stall_cnt, flush_cnt); end
        n_vec++; if (stage_rst !== 5'b00010 || stage_en !== 5'h1F) begin n_err++; $display("FAIL branch_flush got rst=%b en=%h exp 00010 1f", stage_rst, stage_en); end
        next_cycle(); #1;
        n_vec++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd3) begin n_err++; $display("FAIL flush_cnt got %0d %0d exp 1 3", flush_cnt, stall_cnt); end
    endtask

    task automatic test_saturate_and_abort();
        pulse_reset();
        mem_busy = 1'b1;
        repeat (65540) @(posedge clk);
        next_cycle(); #1;
        n_vec++; if (stall_cnt !== 16'hFFFF) begin n_err++; $display("FAIL stall_sat got %h exp ffff", stall_cnt); end
        irq_req = 1'b1;
        next_cycle(); irq_req = 1'b1;
        next_cycle(); irq_req = 1'b1; #1;
        n_vec++; if (irq_take !== 1'b1) begin n_err++; $display("FAIL abort_in_take got take=%0b exp 1", irq_take); end
        rst = 1'b1; #1;
        n_vec++; if (irq_take !== 1'b0 || stage_rst !== 5'h1F || stage_en !== 5'h1F) begin n_err++; $display("FAIL abort_outputs got take=%0b rst=%h en=%h exp 0 1f 1f", irq_take, stage_rst, stage_en); end
        @(negedge clk);
        rst = 1'b0; clear_inputs(); #1;
        n_vec++; if (fsm_state !== 2'd0 || in_service !== 1'b0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin n_err++; $display("FAIL abort_idle got st=%0d svc=%0b cnt=%0d %0d exp 0 0 0 0", fsm_state, in_service, stall_cnt, flush_cnt); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_store_fwd();
        test_irq();
        test_mem_busy();
        test_saturate_and_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
